mips_div_unit: RTL

Multi-cycle 32-bit integer divider for the MIPS datapath. It executes DIV and DIVU and writes quotient to LO and remainder to HI. It sits beside the ALU's carry-lookahead adder tree and performs the inverse operation: restoring division by repeated trial subtraction. It uses a start/busy/done handshake so the pipeline control can stall while the result is produced.

---
 rtl/mips_div_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mips_div_unit.sv
// mips_div_unit
// -------------
// Multi-cycle 32-bit restoring divider for DIV (signed) and DIVU (unsigned).
// The quotient goes to LO and the remainder to HI. The divider converts the
// operands to magnitudes, runs 32 shift/trial-subtract iterations, then
// restores the signs. The remainder always takes the dividend's sign.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request; accepted only in IDLE or DONE
//   is_signed    1 = DIV, 0 = DIVU (sampled with start)
//   dividend     dividend operand (sampled with start)
//   divisor      divisor operand (sampled with start)
//   busy         high while an operation is in flight
//   done         one-cycle pulse when a new result is presented
//   quotient     LO result, held until the next result
//   remainder    HI result, held until the next result
//   div_by_zero  qualifies the held result (divisor was zero)

module mips_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [5:0]  iter;
    logic [31:0] rem_reg;
    logic [31:0] quo_reg;
    logic [31:0] dvsr_reg;
    logic        neg_q;
    logic        neg_r;

    logic        accept;
    logic [31:0] dividend_mag;
    logic [31:0] divisor_mag;
    logic [31:0] shift_rem;
    logic [31:0] shift_quo;
    logic [32:0] trial;

    assign accept = start && ((state == IDLE) || (state == DONE));

    // Magnitudes: only DIV treats bit 31 as a sign. The most negative value
    // maps onto itself, which is still the correct unsigned magnitude.
    assign dividend_mag = (is_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
    assign divisor_mag  = (is_signed && divisor[31])  ? (~divisor + 32'd1)  : divisor;

    // One restoring step on {partial remainder, quotient}.
    assign shift_rem = {rem_reg[30:0], quo_reg[31]};
    assign shift_quo = {quo_reg[30:0], 1'b0};
    // The bit shifted out of the partial remainder becomes the top bit of the
    // trial. This keeps DIVU correct when the divisor magnitude is 2^31 or
    // larger, because the shifted remainder can then need 33 bits.
    assign trial = {rem_reg[31], shift_rem} - {1'b0, dvsr_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            iter        <= 6'd0;
            rem_reg     <= 32'd0;
            quo_reg     <= 32'd0;
            dvsr_reg    <= 32'd0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= 32'd0;
            remainder   <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        if (divisor == 32'd0) begin
                            // Zero divisor: report immediately, busy stays low.
                            quotient    <= 32'hFFFF_FFFF;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            rem_reg  <= 32'd0;
                            quo_reg  <= dividend_mag;
                            dvsr_reg <= divisor_mag;
                            neg_q    <= is_signed && (dividend[31] ^ divisor[31]);
                            neg_r    <= is_signed && dividend[31];
                            iter     <= 6'd0;
                            busy     <= 1'b1;
                            state    <= CALC;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                CALC: begin
                    if (!trial[32]) begin
                        rem_reg <= trial[31:0];
                        quo_reg <= {shift_quo[31:1], 1'b1};
                    end else begin
                        rem_reg <= shift_rem;
                        quo_reg <= shift_quo;
                    end
                    iter <= iter + 6'd1;
                    if (iter == 6'd31) begin
                        state <= SIGN;
                    end
                end

                SIGN: begin
                    quotient    <= neg_q ? (~quo_reg + 32'd1) : quo_reg;
                    remainder   <= neg_r ? (~rem_reg + 32'd1) : rem_reg;
                    div_by_zero <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
